// File: rtl/sha256_msg_sched_if.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched_if
// Valid/ready stream bundle for the SHA-256 message-schedule generator.
//   in_valid  / in_ready  / in_data  : message words W0..W15 into the block
//   out_valid / out_ready / out_data : schedule words W0..W63 out of the block
//   out_idx                          : round index of out_data
//   out_last                         : marks W63
// Modports:
//   slave  : the schedule generator
//   master : the block source / round engine side driving it
// ---------------------------------------------------------------------------
interface sha256_msg_sched_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [5:0]            out_idx;
    logic                  out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched
// SHA-256 message-schedule generator. Loads one 512-bit block as 16 serial
// 32-bit words, then emits W0..W63, one word per output handshake, using a
// 16-word sliding window (win[i] holds W[t+i]).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous flush, aborts the block and returns to LOAD
//   bus   : stream bundle (slave modport), see sha256_msg_sched_if
//   busy  : high while emitting or while a block is partially loaded
// ---------------------------------------------------------------------------
module sha256_msg_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int ROUNDS     = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    sha256_msg_sched_if.slave     bus,
    output logic                  busy
);

    typedef enum logic {
        ST_LOAD,
        ST_EMIT
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_t                r_state;
    logic [3:0]            r_load_cnt;
    logic [5:0]            r_t;
    logic [DATA_WIDTH-1:0] r_win [16];

    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_next;

    function automatic logic [DATA_WIDTH-1:0] rotr(
        input logic [DATA_WIDTH-1:0] x,
        input int unsigned           n
    );
        return (x >> n) | (x << (DATA_WIDTH - n));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sigma0(input logic [DATA_WIDTH-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sigma1(input logic [DATA_WIDTH-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Outputs are decoded from registered state only; out_ready never
    // reaches in_ready or out_valid combinationally.
    assign bus.in_ready  = (r_state == ST_LOAD);
    assign bus.out_valid = (r_state == ST_EMIT);
    assign bus.out_data  = r_win[0];
    assign bus.out_idx   = r_t;
    assign w_last        = (r_t == LAST_IDX);
    assign bus.out_last  = (r_state == ST_EMIT) && w_last;
    assign busy          = (r_state != ST_LOAD) || (r_load_cnt != 4'd0);

    assign w_in_hs  = (r_state == ST_LOAD) && bus.in_valid;
    assign w_out_hs = (r_state == ST_EMIT) && bus.out_ready;

    // W[t+16] from the window: win[14]=W[t+14], win[9]=W[t+9],
    // win[1]=W[t+1], win[0]=W[t].
    assign w_next = sigma1(r_win[14]) + r_win[9] + sigma0(r_win[1]) + r_win[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_LOAD;
            r_load_cnt <= '0;
            r_t        <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else if (clear) begin
            r_state    <= ST_LOAD;
            r_load_cnt <= '0;
            r_t        <= '0;
        end else begin
            // Loading and emitting share one shift; only the word entering
            // win[15] differs.
            if (w_in_hs || w_out_hs) begin
                for (int unsigned i = 0; i < 15; i++) begin
                    r_win[i] <= r_win[i+1];
                end
                r_win[15] <= w_in_hs ? bus.in_data : w_next;
            end

            case (r_state)
                ST_LOAD: begin
                    if (w_in_hs) begin
                        if (r_load_cnt == 4'd15) begin
                            r_load_cnt <= '0;
                            r_t        <= '0;
                            r_state    <= ST_EMIT;
                        end else begin
                            r_load_cnt <= r_load_cnt + 4'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_out_hs) begin
                        if (w_last) begin
                            r_t     <= '0;
                            r_state <= ST_LOAD;
                        end else begin
                            r_t <= r_t + 6'd1;
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_sched
// Self-checking bench for sha256_msg_sched: known-answer vector table,
// random blocks with random stalls against a textbook W[t] recurrence,
// plus hand-written clear and mid-load reset sequences.
// ---------------------------------------------------------------------------
module tb_sha256_msg_sched;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic busy;

    always #5 clk = ~clk;

    sha256_msg_sched_if #(.DATA_WIDTH(32)) bus ();

    sha256_msg_sched #(
        .DATA_WIDTH(32),
        .ROUNDS    (64)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .bus  (bus),
        .busy (busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] exp_w    [64];
    logic [31:0] got_data [64];
    logic [5:0]  got_idx  [64];
    logic        got_last [64];
    int          nhs;

    typedef struct {
        string             name;
        logic [15:0][31:0] blk;
        int                idx;
        logic [31:0]       exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Reference: the full 64-entry schedule from the standard recurrence.
    task automatic build_model(input logic [15:0][31:0] blk);
        for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    task automatic load_block(input logic [15:0][31:0] blk, input bit stall);
        int i = 0;
        int cyc = 0;
        while (i < 16 && cyc < 400) begin
            bus.in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = bus.in_valid ? blk[i] : $urandom;
            if (bus.in_valid && bus.in_ready) i++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("load_count", 32'(i), 32'd16);
        check("latency_out_valid", 32'(bus.out_valid), 32'd1);
        check("emit_in_ready", 32'(bus.in_ready), 32'd0);
        check("emit_busy", 32'(busy), 32'd1);
    endtask

    task automatic emit_block(input bit stall);
        bit          prev_stall = 1'b0;
        logic [31:0] pd = '0;
        logic [5:0]  pi = '0;
        logic        pl = 1'b0;
        int          cyc = 0;
        nhs = 0;
        while (nhs < 64 && cyc < 1000) begin
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data", bus.out_data, pd);
                check("stall_idx", 32'(bus.out_idx), 32'(pi));
                check("stall_last", 32'(bus.out_last), 32'(pl));
            end
            if (bus.out_valid && bus.out_ready) begin
                got_data[nhs] = bus.out_data;
                got_idx[nhs]  = bus.out_idx;
                got_last[nhs] = bus.out_last;
                nhs++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            pd = bus.out_data;
            pi = bus.out_idx;
            pl = bus.out_last;
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        check("handshakes", 32'(nhs), 32'd64);
        check("post_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
        for (int k = 0; k < nhs; k++) begin
            check("out_idx_seq", 32'(got_idx[k]), 32'(k));
            check("out_last_flag", 32'(got_last[k]), 32'(k == 63));
        end
    endtask

    task automatic run_block(input logic [15:0][31:0] blk, input bit stall);
        load_block(blk, stall);
        emit_block(stall);
    endtask

    task automatic compare_model(input logic [15:0][31:0] blk, input string tag);
        build_model(blk);
        for (int k = 0; k < nhs; k++)
            check(tag, got_data[k], exp_w[k]);
    endtask

    logic [15:0][31:0] abc_blk;
    logic [15:0][31:0] sig_blk;
    logic [15:0][31:0] zero_blk;
    logic [15:0][31:0] rnd_blk;
    vec_t              vecs [7];

    initial begin
        abc_blk      = '0;
        abc_blk[0]   = 32'h61626380;
        abc_blk[15]  = 32'h00000018;
        sig_blk      = '0;
        sig_blk[1]   = 32'h00000001;
        zero_blk     = '0;

        vecs[0] = '{"abc_w0",   abc_blk,  0,  32'h61626380};
        vecs[1] = '{"abc_w15",  abc_blk,  15, 32'h00000018};
        vecs[2] = '{"abc_w16",  abc_blk,  16, 32'h61626380};
        vecs[3] = '{"abc_w17",  abc_blk,  17, 32'h000F0000};
        vecs[4] = '{"sig0_w1",  sig_blk,  1,  32'h00000001};
        vecs[5] = '{"sig0_w16", sig_blk,  16, 32'h02004000};
        vecs[6] = '{"zero_w63", zero_blk, 63, 32'h00000000};

        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_idx", 32'(bus.out_idx), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Known-answer table.
        for (int i = 0; i < 7; i++) begin
            run_block(vecs[i].blk, 1'b0);
            check(vecs[i].name, got_data[vecs[i].idx], vecs[i].exp);
        end
        run_block(zero_blk, 1'b0);
        compare_model(zero_blk, "zero_model");

        // Backpressure and input gaps on the "abc" block.
        run_block(abc_blk, 1'b1);
        compare_model(abc_blk, "abc_stall_model");

        // Random blocks with random stalls.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) rnd_blk[i] = $urandom;
            run_block(rnd_blk, 1'b1);
            compare_model(rnd_blk, "rand_model");
        end

        // clear at out_idx 20, coincident with out_ready.
        begin
            int c = 0;
            load_block(abc_blk, 1'b0);
            bus.out_ready = 1'b1;
            while (bus.out_idx != 6'd20 && c < 100) begin
                @(posedge clk); #1;
                c++;
            end
            check("clear_reach_idx20", 32'(bus.out_idx), 32'd20);
            clear = 1'b1;
            @(posedge clk); #1;
            clear = 1'b0;
            bus.out_ready = 1'b0;
            check("clear_out_valid", 32'(bus.out_valid), 32'd0);
            check("clear_in_ready", 32'(bus.in_ready), 32'd1);
            check("clear_out_idx", 32'(bus.out_idx), 32'd0);
            check("clear_busy", 32'(busy), 32'd0);
            run_block(zero_blk, 1'b0);
            compare_model(zero_blk, "clear_zero_model");
        end

        // Asynchronous reset after 7 loaded words.
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = abc_blk[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("partial_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_data", bus.out_data, 32'd0);
        check("arst_out_idx", 32'(bus.out_idx), 32'd0);
        check("arst_out_last", 32'(bus.out_last), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(abc_blk, 1'b0);
        check("arst_abc_w16", got_data[16], 32'h61626380);
        compare_model(abc_blk, "arst_abc_model");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Message-schedule generator for the SHA-256 datapath.
- Accepts one 512-bit block as 16 serial 32-bit words (W0..W15) on a valid/ready input stream.
- Emits the 64-word schedule W0..W63, one word per cycle, on a valid/ready output stream to the compression round engine (the consumer of maj/ch).
- Sits between the padder/block source and the round engine.

Parameters:
- DATA_WIDTH, 32, word width; only 32 is supported (rotation constants are SHA-256 specific).
- ROUNDS, 64, number of schedule words emitted per block.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush; aborts current block and returns to LOAD
- in_valid  input  1  in_data holds a message word
- in_ready  output  1  block can accept a word
- in_data  input  DATA_WIDTH  message word, W0 first, big-endian word order
- out_valid  output  1  out_data holds schedule word W[out_idx]
- out_ready  input  1  consumer accepts the word
- out_data  output  DATA_WIDTH  schedule word W[t]
- out_idx  output  6  round index t, 0..63
- out_last  output  1  high with out_valid when out_idx==63
- busy  output  1  high whenever state != LOAD or load count != 0

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - State = LOAD; load count = 0; t = 0.
  - Window registers win[0..15] = 0.
  - in_ready = 1 (registered or decoded from state, no combinational path from out_ready); out_valid = 0; out_data = 0; out_idx = 0; out_last = 0; busy = 0.
- Storage: 16-entry window win[0..15]; win[i] holds W[t+i].
- State LOAD:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: shift window left (win[i] <= win[i+1]), win[15] <= in_data, load count++.
  - On the 16th accepted word: state <= EMIT, t <= 0, load count <= 0.
- State EMIT:
  - in_ready = 0, out_valid = 1.
  - Outputs: out_data = win[0], out_idx = t, out_last = (t==63).
  - On out_valid & out_ready: shift window left, t++, and win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^32 (carries discarded).
  - sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - Handshake at t==63: state <= LOAD, t <= 0. in_ready rises the next cycle.
  - Values computed into win[15] for t>=48 are never emitted; harmless.
- Timing:
  - Latency: out_valid rises the cycle after the 16th input handshake.
  - Throughput: 1 word/cycle when out_ready is held high; 64 output cycles per block.
  - Block turnaround: 16 load cycles plus 64 emit cycles.
- Backpressure:
  - With out_ready=0, out_data, out_idx and out_last stay stable and the window does not shift.
  - out_valid, once high, does not drop until the handshake.
- Input stalls: in_valid=0 during LOAD holds load count and window.
- clear:
  - Has priority over any handshake in the same cycle.
  - Next cycle: state = LOAD, load count = 0, t = 0, out_valid = 0. Window contents are don't-care.
- Async reset mid-block: everything returns to reset values immediately; the partial block is discarded.
- No overlap: the next block cannot load while EMIT is active.

Test Plan:
- "abc" block: W0=0x61626380, W1..W14=0, W15=0x00000018, out_ready=1 -> 64 consecutive output words.
  - out_idx 0..15 echo the inputs.
  - W16=0x61626380, W17=0x000F0000.
  - out_last only at idx 63; in_ready returns 1 the next cycle.
- sigma0 check: W1=0x00000001, all other input words 0 -> W16=0x02004000.
- All-zero block -> all 64 outputs 0x00000000, out_idx increments 0..63, exactly 64 handshakes.
- Backpressure: random out_ready (about 50%) plus random in_valid gaps on the "abc" block -> identical W sequence to the no-stall run; out_data stable while out_valid & !out_ready.
- clear asserted at out_idx=20 in the same cycle as out_ready=1 -> no handshake counted; out_valid=0 next cycle, in_ready=1; a new all-zero block then yields correct output from idx 0.
- rst_n pulsed low after 7 loaded words -> outputs immediately at reset values; a following full "abc" load produces W16=0x61626380.
